// File: rtl/convn_valid_udiv_62ns_31ns_31_seq.sv
// Sequential unsigned divider: 62-bit dividend / 31-bit divisor, one restoring step per
// ce-enabled cycle. Divide-by-zero and quotient overflow resolve in a single cycle.
module convn_valid_udiv_62ns_31ns_31_seq #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 32,
    parameter int din0_WIDTH = 62,
    parameter int din1_WIDTH = 31,
    parameter int dout_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  done,
    output logic                  busy,
    output logic                  ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CNT_W = $clog2(dout_WIDTH);
    localparam int SH_W  = din1_WIDTH + 1;

    // Latency is one accept cycle plus one cycle per quotient bit.
    if (NUM_STAGE != dout_WIDTH + 1 || ID < 0) begin : g_param_check
        $error("NUM_STAGE must equal dout_WIDTH+1 and ID must be non-negative");
    end

    logic [1:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [din1_WIDTH-1:0] prem;
    logic [dout_WIDTH-1:0] dvd_lo;
    logic [din1_WIDTH-1:0] dsr;
    logic [dout_WIDTH-2:0] quo;

    logic [din1_WIDTH-1:0] dvd_hi;
    logic [SH_W-1:0]       shifted;
    logic [SH_W-1:0]       diff;
    logic                  qbit;
    logic [din1_WIDTH-1:0] prem_nxt;

    // The remainder is always below the divisor, so only the shifted value needs the extra
    // bit; a borrow out of the trial subtraction shows up as diff's top bit.
    always_comb begin
        dvd_hi   = din0[din0_WIDTH-1 -: din1_WIDTH];
        shifted  = {prem, dvd_lo[dout_WIDTH-1]};
        diff     = shifted - {1'b0, dsr};
        qbit     = ~diff[SH_W-1];
        prem_nxt = qbit ? diff[din1_WIDTH-1:0] : shifted[din1_WIDTH-1:0];
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dout  <= '0;
            rem   <= '0;
            ovf   <= 1'b0;
        end else if (ce) begin
            case (state)
                CALC: begin
                    prem   <= prem_nxt;
                    dvd_lo <= {dvd_lo[dout_WIDTH-2:0], 1'b0};
                    quo    <= {quo[dout_WIDTH-3:0], qbit};
                    if (cnt == '0) begin
                        state <= DONE;
                        dout  <= {quo, qbit};
                        rem   <= prem_nxt;
                        ovf   <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE, DONE: begin
                    if (start) begin
                        dsr    <= din1;
                        dvd_lo <= din0[dout_WIDTH-1:0];
                        prem   <= dvd_hi;
                        if (din1 == '0) begin
                            state <= DONE;
                            dout  <= '1;
                            rem   <= din0[din1_WIDTH-1:0];
                            ovf   <= 1'b1;
                        end else if (dvd_hi >= din1) begin
                            state <= DONE;
                            dout  <= '1;
                            rem   <= '0;
                            ovf   <= 1'b1;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_W'(dout_WIDTH - 1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/convn_valid_udiv_62ns_31ns_31_seq.md
CONVN_VALID_UDIV_62NS_31NS_31_SEQ -- requirements
Module: convn_valid_udiv_62ns_31ns_31_seq

Interface
REQ-001 SHALL provide parameters: ID, 1, instance tag (no functional effect); NUM_STAGE, 32, start-to-done latency in ce-enabled cycles; din0_WIDTH, 62, dividend width; din1_WIDTH, 31, divisor width; dout_WIDTH, 31, quotient width.
REQ-002 SHALL provide ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- ce  in  1  clock enable; low freezes all state
- start  in  1  request; operands sampled when accepted
- din0  in  62  unsigned dividend
- din1  in  31  unsigned divisor
- dout  out  31  unsigned quotient
- rem  out  31  unsigned remainder
- done  out  1  one-cycle result-valid pulse
- busy  out  1  high while a division is in progress
- ovf  out  1  divide-by-zero or quotient overflow flag, valid with done

Function
REQ-003 SHALL implement FSM with states IDLE, CALC, DONE; reset state IDLE.
REQ-004 SHALL accept start only when ce=1 and state is IDLE or DONE; start in CALC is ignored and does not alter operands.
REQ-005 On acceptance, SHALL latch din0 and din1 internally; later input changes have no effect on the operation in progress.
REQ-006 If the latched din1==0: next state DONE; dout=31'h7FFFFFFF, rem=din0[30:0], ovf=1; done high in the cycle after acceptance.
REQ-007 Else if din0[61:31] >= din1 (quotient exceeds 31 bits): next state DONE; dout=31'h7FFFFFFF, rem=0, ovf=1; done high in the cycle after acceptance.
REQ-008 Otherwise next state CALC with a 32-bit partial remainder initialised to {1'b0, din0[61:31]}, an iteration counter set to 30, and ovf=0.
REQ-009 In CALC, each ce-enabled cycle SHALL perform one restoring step, producing one quotient bit, MSB first: shift in the next dividend bit (din0[30] down to din0[0]); subtract din1 if the result is >= din1; record the quotient bit.
REQ-010 CALC SHALL last exactly 31 ce-enabled cycles; after the step at counter 0, next state DONE.
REQ-011 With ce held high, done SHALL assert exactly 32 cycles after the accepting cycle (NUM_STAGE), for exactly one cycle.
REQ-012 In DONE: done=1; dout=floor(din0/din1); rem=din0 mod din1 (remainder < din1, fits 31 bits). Without a new start, next state IDLE.
REQ-013 dout, rem and ovf SHALL hold their values after DONE until the next accepted start produces a new result; they SHALL not show intermediate values during CALC.
REQ-014 A start accepted in DONE SHALL begin the next division with no idle gap (back-to-back throughput: one result per 32 cycles).
REQ-015 busy SHALL be 1 in CALC and 0 in IDLE and DONE.
REQ-016 With ce=0, state, counter, partial remainder, outputs and done SHALL all hold; a done pulse in progress extends until the next ce-enabled edge; latency counts only ce-enabled cycles.
REQ-017 No combinational path from any input to any output.

Reset
REQ-018 reset=1 at a rising edge SHALL force state IDLE, dout=0, rem=0, done=0, busy=0, ovf=0, counter=0, regardless of ce.
REQ-019 Reset asserted mid-CALC SHALL abandon the operation; no done pulse follows; start is ignored while reset=1.
REQ-020 The first start accepted after reset deasserts SHALL behave per REQ-004..REQ-012.

Verification
REQ-021 din0=100, din1=7, start one cycle, ce=1 -> done at cycle 32, dout=14, rem=2, ovf=0, busy high cycles 1-31.
REQ-022 din1=2^31-1, din0=(2^31-1)^2+(2^31-2) -> dout=2^31-1, rem=2^31-2, ovf=0 at cycle 32.
REQ-023 din0=5, din1=0 -> done at cycle 1, dout=7FFFFFFF, rem=5, ovf=1; then din0=2^61, din1=1 -> done at cycle 1, ovf=1, rem=0.
REQ-024 100/7 with ce=0 for 5 cycles during CALC -> done at cycle 37, same result; done pulse held through a ce-low cycle.
REQ-025 Start in CALC with different operands -> ignored, first result correct; start asserted during the DONE cycle -> second result 32 cycles after the first.
REQ-026 reset at cycle 10 of CALC -> all outputs 0 next cycle, no done; new 1000/10 start -> dout=100, rem=0.
